dense_layer: RTL and testbench
==============================

// Module: dense_layer
// PURPOSE
// - Fully-connected (dense) layer core: for a batch of B input vectors (N features each) and an
//   M x N weight matrix, computes result[b][m] = sum_n inputs[b][n]*weights[m][n] in signed Qx.FRAC.
// - No bias and no activation; downstream blocks add those. All B*M dot products run in parallel.
// - Feeds the NN inference datapath. Operands come from parameter/feature buffers.
// PARAMETERS
// - B      2   batch size (input vectors per transaction)
// - M      3   output neurons (weight rows)
// - N      4   input features (weight columns)
// - WIDTH 16   signed operand/result width, two's complement
// - FRAC   8   fractional bits (default Q8.8); 0 <= FRAC < WIDTH
// PORTS
// - clk       in   1                    rising-edge clock
// - rst_n     in   1                    asynchronous active-low reset
// - in_valid  in   1                    weights/inputs valid this cycle; captured on clk edge
// - weights   in   [M][N] x WIDTH s     weight matrix, row m = neuron m
// - inputs    in   [B][N] x WIDTH s     input batch
// - out_valid out  1                    result holds a newly computed transaction
// - result    out  [B][M] x WIDTH s     layer outputs
// BEHAVIOUR
// - Reset (rst_n low, async): out_valid=0, every result[b][m]=0, stage-1 valid=0.
//   Stays in reset while low; pipeline flushes and in-flight data is dropped.
// - Two-stage pipeline, no backpressure, one transaction per cycle accepted.
//   Stage 1 (edge k, in_valid=1): register weights and inputs, s1_valid<=1.
//   Stage 2 (edge k+1): register the computed result, out_valid<=1. Latency 2 cycles.
// - out_valid follows s1_valid each cycle: it is a one-cycle pulse per transaction.
// - result holds its last value when no new transaction completes.
// - Operands are not captured when in_valid=0. Back-to-back in_valid gives back-to-back outputs.
// - Arithmetic:
//   - Each product is full precision, 2*WIDTH bits.
//   - Accumulator is ACC_W = 2*WIDTH + $clog2(N) + 1 bits, so it cannot overflow.
//   - Rescale: acc >>> FRAC (arithmetic shift). This truncates toward -inf; there is no rounding.
//   - Saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1]. Never wrap.
// - Reduction order is irrelevant because the accumulator is exact and the result is bit-exact.
// STRUCTURE
// - Package dense_pkg:
//   - ACC_W function of WIDTH and N.
//   - sat_rescale(acc) function: shift by FRAC, then clamp to WIDTH.
//   - Default WIDTH/FRAC constants.
// - Sub-module dense_dot: combinational N-element signed dot product of two WIDTH-bit vectors,
//   with rescale and saturate.
// - dense_layer instantiates B*M dense_dot units in a generate loop and adds both pipeline
//   register stages.
// TESTING (Q8.8, 1.0 = 256)
// - Basic: inputs[0]={256,512,-256,128}, weights[0]={128,128,128,128}, pulse in_valid.
//   Required: 2 cycles later out_valid=1 and result[0][0]=320 (1.25).
// - Identity: weights[m] = unit vector e_m (256 at index m).
//   Required: result[b][m] = inputs[b][m] for all b and m, including negative inputs.
// - Truncation: inputs[0][0]=1 with weight 128 gives result 0; inputs[0][0]=-1 with weight 128
//   gives result -1. All other operands are 0.
// - Saturation: all operands 32767 -> result 32767. Inputs 32767 with weights -32768
//   -> result -32768.
// - Streaming: in_valid high for 3 consecutive cycles with distinct operands.
//   Required: 3 consecutive out_valid cycles with matching results in order; result holds afterwards.
// - Reset mid-operation: drop rst_n one cycle after in_valid.
//   Required: out_valid=0 and result=0 immediately; no output appears after release.

Source files
------------

// File: rtl/dense_pkg.sv
// Shared constants and arithmetic helpers for the dense-layer datapath.
// Accumulator sizing and the fixed-point rescale/saturate step live here.
package dense_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int FRAC_DEF  = 8;

  // Wide enough for any practical accumulator; callers narrow the result explicitly.
  localparam int WIDE_W = 128;
  typedef logic signed [WIDE_W-1:0] wide_t;

  // Exact accumulator width: full-precision products plus growth for N terms and a guard bit.
  function automatic int acc_w(input int width, input int n);
    return 2 * width + $clog2(n) + 1;
  endfunction

  // Arithmetic shift (floor toward -inf, no rounding), then clamp to the signed WIDTH range.
  function automatic wide_t sat_rescale(input wide_t acc, input int width, input int frac);
    wide_t shifted;
    wide_t hi;
    wide_t lo;
    shifted = acc >>> frac;
    hi      = (wide_t'(1) <<< (width - 1)) - wide_t'(1);
    lo      = -(wide_t'(1) <<< (width - 1));
    if (shifted > hi) return hi;
    if (shifted < lo) return lo;
    return shifted;
  endfunction

endpackage

// File: rtl/dense_dot.sv
// Combinational signed dot product of two N-element vectors in Qx.FRAC,
// exact accumulation followed by rescale and saturation to WIDTH bits.
module dense_dot
  import dense_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic [N-1:0][WIDTH-1:0] x,
  input  logic [N-1:0][WIDTH-1:0] w,
  output logic [WIDTH-1:0]        y
);

  localparam int ACC_W  = acc_w(WIDTH, N);
  localparam int PROD_W = 2 * WIDTH;

  logic signed [PROD_W-1:0] prod [N];
  logic signed [ACC_W-1:0]  acc;

  // Sign-extend both operands first so the multiply is full precision.
  for (genvar i = 0; i < N; i++) begin : g_prod
    assign prod[i] = PROD_W'($signed(x[i])) * PROD_W'($signed(w[i]));
  end

  // NOTE: always_comb uses blocking '=' and assigns every output first, so no latch is inferred.
  always_comb begin
    acc = '0;
    for (int i = 0; i < N; i++) begin
      acc = acc + ACC_W'(prod[i]);
    end
    y = WIDTH'(sat_rescale(wide_t'(acc), WIDTH, FRAC));
  end

endmodule

// File: rtl/dense_layer.sv
// Dense layer core: B x M parallel dot products over a two-stage pipeline
// (operand capture, then result register). No bias, no activation.
module dense_layer
  import dense_pkg::*;
#(
  parameter int B     = 2,
  parameter int M     = 3,
  parameter int N     = 4,
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic [M-1:0][N-1:0][WIDTH-1:0] weights,
  input  logic [B-1:0][N-1:0][WIDTH-1:0] inputs,
  output logic                           out_valid,
  output logic [B-1:0][M-1:0][WIDTH-1:0] result
);

  logic                           s1_valid;
  logic [M-1:0][N-1:0][WIDTH-1:0] weights_q;
  logic [B-1:0][N-1:0][WIDTH-1:0] inputs_q;
  logic [B-1:0][M-1:0][WIDTH-1:0] dot;

  // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (s1_valid) begin
        result <= dot;
      end
    end
  end

  // NOTE: operand registers are deliberately not reset; s1_valid gates their use after reset.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      weights_q <= weights;
      inputs_q  <= inputs;
    end
  end

  for (genvar gb = 0; gb < B; gb++) begin : g_batch
    for (genvar gm = 0; gm < M; gm++) begin : g_neuron
      dense_dot #(
        .N     (N),
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
      ) u_dot (
        .x (inputs_q[gb]),
        .w (weights_q[gm]),
        .y (dot[gb][gm])
      );
    end
  end

endmodule

// File: tb/tb_dense_layer.sv
// Self-checking bench for dense_layer: a floor-division reference model with a
// per-cycle compare process, plus hand-computed Q8.8 directed expectations.
module tb_dense_layer;

  localparam int B     = 2;
  localparam int M     = 3;
  localparam int N     = 4;
  localparam int WIDTH = 16;
  localparam int FRAC  = 8;

  typedef logic [M-1:0][N-1:0][WIDTH-1:0] wt_t;
  typedef logic [B-1:0][N-1:0][WIDTH-1:0] in_t;
  typedef logic [B-1:0][M-1:0][WIDTH-1:0] res_t;
  typedef struct {
    int   due;
    res_t res;
  } exp_t;

  logic clk      = 1'b0;
  logic rst_n    = 1'b1;
  logic in_valid = 1'b0;
  wt_t  weights  = '0;
  in_t  inputs   = '0;
  logic out_valid;
  res_t result;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t q[$];
  res_t last_res = '0;

  dense_layer #(
    .B     (B),
    .M     (M),
    .N     (N),
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .weights   (weights),
    .inputs    (inputs),
    .out_valid (out_valid),
    .result    (result)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: exact integer dot product, floor division by 2^FRAC, clamp.
  function automatic res_t model(input wt_t w, input in_t x);
    res_t   r;
    longint acc;
    longint q_val;
    longint div;
    div = longint'(1) << FRAC;
    for (int b = 0; b < B; b++) begin
      for (int m = 0; m < M; m++) begin
        acc = 0;
        for (int n = 0; n < N; n++) begin
          acc += longint'($signed(x[b][n])) * longint'($signed(w[m][n]));
        end
        q_val = acc / div;
        if (acc < 0 && (acc % div) != 0) q_val -= 1;
        if (q_val > 32767) q_val = 32767;
        if (q_val < -32768) q_val = -32768;
        r[b][m] = q_val[WIDTH-1:0];
      end
    end
    return r;
  endfunction

  // Compare process: checks outputs each falling edge against the model's expectations.
  always @(negedge clk) begin
    logic exp_v;
    if (!rst_n) begin
      q.delete();
      last_res = '0;
      check("reset_out_valid", longint'(out_valid), 0);
      for (int b = 0; b < B; b++)
        for (int m = 0; m < M; m++)
          check("reset_result", longint'($signed(result[b][m])), 0);
    end else begin
      exp_v = (q.size() > 0) && (q[0].due == cyc);
      check("out_valid", longint'(out_valid), longint'(exp_v));
      if (exp_v) begin
        last_res = q[0].res;
        void'(q.pop_front());
      end
      for (int b = 0; b < B; b++)
        for (int m = 0; m < M; m++)
          check("result", longint'($signed(result[b][m])), longint'($signed(last_res[b][m])));
      if (in_valid) q.push_back('{cyc + 2, model(weights, inputs)});
    end
  end

  // Drive one transaction at posedge+1, then wait until its output is visible.
  task automatic send(input wt_t w, input in_t x);
    weights  = w;
    inputs   = x;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  function automatic wt_t identity_w();
    wt_t w = '0;
    for (int m = 0; m < M; m++) w[m][m] = 16'd256;
    return w;
  endfunction

  initial begin
    wt_t w;
    in_t x;
    int  idv[B][N];
    idv = '{'{100, -300, 7, 55}, '{-1, 32767, -32768, 4}};

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("lit_reset_valid", longint'(out_valid), 0);
    check("lit_reset_r00", longint'($signed(result[0][0])), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic: 256*128 + 512*128 - 256*128 + 128*128 = 81920 -> 320
    w = '0; x = '0;
    for (int n = 0; n < N; n++) w[0][n] = 16'd128;
    x[0][0] = 16'd256; x[0][1] = 16'd512; x[0][2] = -16'sd256; x[0][3] = 16'd128;
    send(w, x);
    check("basic_valid", longint'(out_valid), 1);
    check("basic_r00", longint'($signed(result[0][0])), 320);

    // Identity weights pass inputs straight through.
    x = '0;
    for (int b = 0; b < B; b++)
      for (int n = 0; n < N; n++) x[b][n] = WIDTH'(idv[b][n]);
    send(identity_w(), x);
    for (int b = 0; b < B; b++)
      for (int m = 0; m < M; m++)
        check("identity", longint'($signed(result[b][m])), longint'(idv[b][m]));

    // Truncation toward -inf.
    w = '0; x = '0;
    w[0][0] = 16'd128; x[0][0] = 16'd1;
    send(w, x);
    check("trunc_pos", longint'($signed(result[0][0])), 0);
    x[0][0] = 16'hFFFF;
    send(w, x);
    check("trunc_neg", longint'($signed(result[0][0])), -1);

    // Saturation at both rails.
    for (int m = 0; m < M; m++) for (int n = 0; n < N; n++) w[m][n] = 16'h7FFF;
    for (int b = 0; b < B; b++) for (int n = 0; n < N; n++) x[b][n] = 16'h7FFF;
    send(w, x);
    check("sat_pos_r00", longint'($signed(result[0][0])), 32767);
    check("sat_pos_r12", longint'($signed(result[1][2])), 32767);
    for (int m = 0; m < M; m++) for (int n = 0; n < N; n++) w[m][n] = 16'h8000;
    send(w, x);
    check("sat_neg_r00", longint'($signed(result[0][0])), -32768);
    check("sat_neg_r12", longint'($signed(result[1][2])), -32768);

    // Streaming: three back-to-back transactions, results in order, then hold.
    x = '0;
    weights  = identity_w();
    x[0][0]  = 16'd10; inputs = x; in_valid = 1'b1;
    @(posedge clk); #1;
    x[0][0]  = 16'd20; inputs = x;
    @(posedge clk); #1;
    check("stream_v0", longint'(out_valid), 1);
    check("stream_r0", longint'($signed(result[0][0])), 10);
    x[0][0]  = 16'd30; inputs = x;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("stream_v1", longint'(out_valid), 1);
    check("stream_r1", longint'($signed(result[0][0])), 20);
    @(posedge clk); #1;
    check("stream_v2", longint'(out_valid), 1);
    check("stream_r2", longint'($signed(result[0][0])), 30);
    @(posedge clk); #1;
    check("stream_idle", longint'(out_valid), 0);
    check("stream_hold", longint'($signed(result[0][0])), 30);

    // Reset one cycle after in_valid: captured transaction is dropped.
    x[0][0] = 16'd77; inputs = x; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_valid", longint'(out_valid), 0);
    check("midrst_r00", longint'($signed(result[0][0])), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("midrst_no_output", longint'(out_valid), 0);
      check("midrst_r00_hold", longint'($signed(result[0][0])), 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", longint'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
